// File: rtl/xadc_drp_sequencer_if.sv
`default_nettype none
// ==== xadc_drp_sequencer_if : XADC DRP read bus, sequencer is master | rev 1.0 ====
interface xadc_drp_sequencer_if;
   logic        den;
   logic        dwe;
   logic [6:0]  daddr;
   logic [15:0] drp_do;
   logic        drdy;

   modport master (output den, dwe, daddr, input drp_do, drdy);
   modport slave  (input den, dwe, daddr, output drp_do, drdy);
endinterface
`default_nettype wire

// File: rtl/xadc_drp_sequencer.sv
`default_nettype none
// ==== xadc_drp_sequencer : round-robin XADC DRP channel reader with watchdog | rev 1.0 ====
module xadc_drp_sequencer #(
   parameter logic [6:0]  ADDR0          = 7'h1E,
   parameter logic [6:0]  ADDR1          = 7'h17,
   parameter logic [6:0]  ADDR2          = 7'h1F,
   parameter logic [6:0]  ADDR3          = 7'h16,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  wire logic              clk,
   input  wire logic              resetn,
   input  wire logic [3:0]        ch_enable,
   input  wire logic              eoc,
   xadc_drp_sequencer_if.master   drp,
   output logic [47:0]            ch_data,
   output logic [11:0]            sample_data,
   output logic [1:0]             sample_ch,
   output logic                   sample_valid,
   output logic                   busy,
   output logic                   timeout_err,
   input  wire logic              err_clear
);

   localparam logic [1:0]  c_st_idle  = 2'd0;
   localparam logic [1:0]  c_st_issue = 2'd1;
   localparam logic [1:0]  c_st_wait  = 2'd2;
   localparam logic [15:0] c_timeout  = 16'(TIMEOUT_CYCLES);

   logic [1:0]  r_state;
   logic [1:0]  w_next;
   logic [1:0]  r_last_ch;
   logic [1:0]  w_sel_ch;
   logic [6:0]  w_sel_addr;
   logic [15:0] r_wdog;
   logic        w_start;
   logic        w_capture;
   logic        w_expire;

   logic        r_den;
   logic        r_busy;
   logic [6:0]  r_daddr;
   logic [47:0] r_ch_data;
   logic [11:0] r_sample_data;
   logic [1:0]  r_sample_ch;
   logic        r_sample_valid;
   logic        r_timeout_err;
   logic        w_unused_lsb;

   // Scan last_ch+4 down to last_ch+1 so the nearest enabled successor wins.
   always_comb begin
      w_sel_ch = r_last_ch;
      for (int k = 4; k >= 1; k--) begin
         if (ch_enable[r_last_ch + 2'(k)]) begin
            w_sel_ch = r_last_ch + 2'(k);
         end
      end
   end

   always_comb begin
      w_sel_addr = ADDR0;
      case (w_sel_ch)
         2'd1:    w_sel_addr = ADDR1;
         2'd2:    w_sel_addr = ADDR2;
         2'd3:    w_sel_addr = ADDR3;
         default: w_sel_addr = ADDR0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_state <= c_st_idle;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         c_st_idle: begin
            if (eoc && (ch_enable != 4'b0000)) begin
               w_next = c_st_issue;
            end
         end
         c_st_issue: w_next = c_st_wait;
         c_st_wait: begin
            if (drp.drdy || (r_wdog == c_timeout)) begin
               w_next = c_st_idle;
            end
         end
         default: w_next = c_st_idle;
      endcase
   end

   always_comb begin
      w_start   = (r_state == c_st_idle) && eoc && (ch_enable != 4'b0000);
      w_capture = (r_state == c_st_wait) && drp.drdy;
      w_expire  = (r_state == c_st_wait) && !drp.drdy && (r_wdog == c_timeout);
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_den          <= 1'b0;
         r_busy         <= 1'b0;
         r_daddr        <= 7'h00;
         r_last_ch      <= 2'd3;
         r_wdog         <= 16'h0000;
         r_ch_data      <= 48'h0;
         r_sample_data  <= 12'h000;
         r_sample_ch    <= 2'd0;
         r_sample_valid <= 1'b0;
         r_timeout_err  <= 1'b0;
      end else begin
         r_den          <= (w_next == c_st_issue);
         r_busy         <= (w_next != c_st_idle);
         r_sample_valid <= w_capture;
         if (w_start) begin
            r_daddr   <= w_sel_addr;
            r_last_ch <= w_sel_ch;
         end
         if (r_state == c_st_issue) begin
            r_wdog <= 16'h0000;
         end else if ((r_state == c_st_wait) && !drp.drdy && !w_expire) begin
            r_wdog <= r_wdog + 16'd1;
         end
         // last_ch still names the in-flight channel while waiting for drdy.
         if (w_capture) begin
            for (int i = 0; i < 4; i++) begin
               if (r_last_ch == 2'(i)) begin
                  r_ch_data[12*i +: 12] <= drp.drp_do[15:4];
               end
            end
            r_sample_data <= drp.drp_do[15:4];
            r_sample_ch   <= r_last_ch;
         end
         if (w_expire) begin
            r_timeout_err <= 1'b1;
         end else if (err_clear) begin
            r_timeout_err <= 1'b0;
         end
      end
   end

   assign w_unused_lsb = ^drp.drp_do[3:0];

   assign drp.den      = r_den;
   assign drp.dwe      = 1'b0;
   assign drp.daddr    = r_daddr;
   assign ch_data      = r_ch_data;
   assign sample_data  = r_sample_data;
   assign sample_ch    = r_sample_ch;
   assign sample_valid = r_sample_valid;
   assign busy         = r_busy;
   assign timeout_err  = r_timeout_err;

endmodule
`default_nettype wire

// File: doc/xadc_drp_sequencer.md
# xadc_drp_sequencer

Round-robin scheduler for the XADC dynamic reconfiguration port (DRP). It drives `den`/`daddr` towards the XADC wizard and services one auxiliary channel per end-of-conversion event, chosen from a runtime enable mask. It captures each returned sample into a per-channel register bank and flags a stalled DRP read with a watchdog. It sits between the XADC primitive and the consumers of ADC data: the LED PWM stage and the filter datapath.

## Interface
- `ADDR0`, default 7'h1E: DRP address of channel 0 (VAUX14).
- `ADDR1`, default 7'h17: DRP address of channel 1 (VAUX7).
- `ADDR2`, default 7'h1F: DRP address of channel 2 (VAUX15).
- `ADDR3`, default 7'h16: DRP address of channel 3 (VAUX6).
- `TIMEOUT_CYCLES`, default 255: maximum cycles to wait for `drdy` after `den`. Range 1..65535.

Ports:
- `clk`  in  1  sole clock; the XADC `dclk_in` domain.
- `resetn`  in  1  reset, synchronous, active-low.
- `ch_enable`  in  4  per-channel service enable; bit i enables channel i.
- `eoc`  in  1  XADC end-of-conversion pulse.
- `den`  out  1  DRP enable to XADC.
- `dwe`  out  1  DRP write enable; constant 0.
- `daddr`  out  7  DRP address.
- `drp_do`  in  16  DRP read data.
- `drdy`  in  1  DRP data ready.
- `ch_data`  out  48  sample bank; channel i occupies bits [12i+11:12i].
- `sample_data`  out  12  most recent sample.
- `sample_ch`  out  2  channel index of `sample_data`.
- `sample_valid`  out  1  one-cycle strobe when `sample_data`/`sample_ch` update.
- `busy`  out  1  high in any state other than IDLE.
- `timeout_err`  out  1  sticky watchdog flag.
- `err_clear`  in  1  clears `timeout_err`.

## Operation
- FSM with three states: IDLE, ISSUE, WAIT.
- IDLE:
  - If `eoc`=1 and `ch_enable`≠0, select a channel and go to ISSUE.
  - Otherwise remain in IDLE. `drdy` seen in IDLE is ignored.
- Channel selection is round-robin. `last_ch` (2 bits) holds the last serviced channel. The selected channel is the first enabled channel among `last_ch`+1, +2, +3, +4 (mod 4). If only `last_ch` is enabled, it is selected again.
- On selection:
  - `daddr` is loaded with the ADDRn of the selected channel.
  - `last_ch` is updated to the selected channel.
  - `daddr` holds that value until the next selection.
- ISSUE: `den`=1 for exactly one cycle, then go to WAIT and clear the watchdog counter to 0.
- WAIT:
  - On `drdy`=1: write `drp_do[15:4]` into the selected channel's slot in `ch_data` and into `sample_data`; set `sample_ch`; pulse `sample_valid`; return to IDLE.
  - Otherwise the counter increments. When it reaches `TIMEOUT_CYCLES`, set `timeout_err` and return to IDLE. No sample is written and there is no `sample_valid`. `last_ch` keeps its advanced value.
- `eoc` arriving in ISSUE or WAIT is dropped; it is not queued.
- `ch_enable` is sampled only at selection. Changing it mid-read does not abort the in-flight read.
- `timeout_err` is cleared by `err_clear`=1. If a set and a clear occur in the same cycle, set wins.
- Reset (`resetn`=0 at a clock edge) sets:
  - state IDLE;
  - `den`, `daddr`, `ch_data`, `sample_data`, `sample_ch`, `sample_valid`, `busy`, `timeout_err` all 0;
  - `last_ch`=3, so channel 0 is served first.
- Reset mid-read abandons the read. A late `drdy` after reset is ignored because the FSM is in IDLE.

## Timing
- All outputs are registered. `dwe` is tied to 0.
- `eoc` sampled high at edge T (FSM in IDLE):
  - `daddr` is valid and `busy`=1 from T+1;
  - `den`=1 during T+1 → T+2 only.
- `drdy` sampled high at edge D:
  - `ch_data`, `sample_data`, `sample_ch` update at D+1;
  - `sample_valid`=1 for the cycle D+1 → D+2;
  - `busy`=0 and state IDLE from D+1;
  - an `eoc` sampled at D+1 is accepted.
- `drdy` in the same cycle as `den` is not accepted; capture is only in WAIT.
- Timeout: with `den` in cycle T+1 and no `drdy`, `timeout_err`=1 and `busy`=0 exactly `TIMEOUT_CYCLES`+1 edges after the first WAIT edge.
- Minimum service period is 3 cycles: `eoc` → ISSUE → WAIT with immediate `drdy` → IDLE.

## Test plan
- **Reset, then round-robin.** `ch_enable`=4'b1111, `eoc` every 50 cycles, XADC model returns `drdy` 4 cycles after `den` with `drp_do`=16'hABC0 → `daddr` sequence 1E,17,1F,16,1E; `sample_data`=12'hABC on each; `sample_ch` 0,1,2,3,0; exactly one `sample_valid` per `eoc`.
- **Sparse mask.** `ch_enable`=4'b1010 → channels 1,3,1,3. Switch to 4'b0100 mid-WAIT → the current read completes; all subsequent reads target 7'h1F. `ch_enable`=0 → `eoc` ignored, `den` stays 0.
- **Dropped eoc.** Assert `eoc` while `busy`=1 → no second `den`; next `den` only after the next IDLE `eoc`.
- **Timeout.** `TIMEOUT_CYCLES`=8, model never asserts `drdy` → `timeout_err`=1 exactly 9 edges after entering WAIT; no `sample_valid`; the next `eoc` serves the next channel. Assert `err_clear` with no new timeout → flag clears. Assert `err_clear` in the same cycle as a timeout → flag stays 1.
- **Reset mid-read.** Assert `resetn`=0 for one edge in WAIT, then deliver `drdy` → all outputs 0, no capture; the next `eoc` reads channel 0 (7'h1E).
- **Back-to-back.** `drdy` 1 cycle after `den` and `eoc` asserted at D+1 → new `den` at D+2; period of 3 cycles verified; `ch_data` slots are independent and untouched by other channels.
